// File: rtl/lvds_tx.sv
// LVDS I/Q transmitter: frames one 14-bit I/Q pair into a 32-bit sync-tagged word
// and shifts it out MSB-first as 16 dibits, with a one-entry buffer for gapless frames.
module lvds_tx #(
  parameter logic [1:0] IDLE_DIBIT = 2'b00
) (
  input  logic        i_ddr_clk,
  input  logic        i_reset,
  input  logic        i_tx_en,
  input  logic [13:0] i_sample_i,
  input  logic [13:0] i_sample_q,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [1:0]  o_ddr_data,
  output logic        o_frame_start,
  output logic        o_busy,
  output logic        o_underrun
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state;
  logic [31:0] hold_frame_p0;
  logic        hold_vld_p0;
  logic [29:0] shift_p1;
  logic [3:0]  idx;

  logic accept;
  logic last;
  logic load;

  function automatic logic [31:0] pack_frame(input logic [13:0] si, input logic [13:0] sq);
    return {2'b10, si, 2'b01, sq};
  endfunction

  assign o_ready = !hold_vld_p0 && !i_reset;
  // Reset is handled by the async branch, so the accept term need not see it.
  assign accept  = i_valid && !hold_vld_p0;
  assign last    = (state == SEND) && (idx == 4'd15);
  assign load    = hold_vld_p0 && i_tx_en && ((state == IDLE) || last);

  // Stage p0 -> p1: holding buffer capture and shifter load/advance
  always_ff @(posedge i_ddr_clk) begin
    if (accept) begin
      hold_frame_p0 <= pack_frame(i_sample_i, i_sample_q);
    end
    if (load) begin
      shift_p1 <= hold_frame_p0[29:0];
    end else begin
      shift_p1 <= {shift_p1[27:0], 2'b00};
    end
  end

  // Stage p1 -> output: FSM, dibit register and status flags
  always_ff @(posedge i_ddr_clk or posedge i_reset) begin
    if (i_reset) begin
      state         <= IDLE;
      hold_vld_p0   <= 1'b0;
      idx           <= 4'd0;
      o_ddr_data    <= IDLE_DIBIT;
      o_frame_start <= 1'b0;
      o_busy        <= 1'b0;
      o_underrun    <= 1'b0;
    end else begin
      o_frame_start <= 1'b0;
      o_underrun    <= 1'b0;

      if (accept) begin
        hold_vld_p0 <= 1'b1;
      end else if (load) begin
        hold_vld_p0 <= 1'b0;
      end

      if (load) begin
        o_ddr_data    <= hold_frame_p0[31:30];
        o_frame_start <= 1'b1;
        o_busy        <= 1'b1;
        idx           <= 4'd0;
        state         <= SEND;
      end else begin
        case (state)
          IDLE: begin
            o_ddr_data <= IDLE_DIBIT;
            o_busy     <= 1'b0;
          end
          SEND: begin
            if (idx != 4'd15) begin
              o_ddr_data <= shift_p1[29:28];
              idx        <= idx + 4'd1;
              o_busy     <= 1'b1;
            end else begin
              // Frame done with nothing to send: idle, flag starvation only if enabled.
              o_ddr_data <= IDLE_DIBIT;
              o_busy     <= 1'b0;
              o_underrun <= i_tx_en;
              state      <= IDLE;
            end
          end
          default: begin
            o_ddr_data <= IDLE_DIBIT;
            o_busy     <= 1'b0;
            state      <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lvds_tx.sv
// Self-checking bench for lvds_tx: frame-level reference model, bench-side deframer
// and an in-order scoreboard of accepted samples versus received frames.
module tb_lvds_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_en;
  logic [13:0] si;
  logic [13:0] sq;
  logic        valid;
  logic        ready;
  logic [1:0]  ddr;
  logic        fs;
  logic        busy;
  logic        ur;

  always #5 clk = ~clk;

  lvds_tx #(.IDLE_DIBIT(2'b00)) dut (
    .i_ddr_clk(clk),
    .i_reset(rst),
    .i_tx_en(tx_en),
    .i_sample_i(si),
    .i_sample_q(sq),
    .i_valid(valid),
    .o_ready(ready),
    .o_ddr_data(ddr),
    .o_frame_start(fs),
    .o_busy(busy),
    .o_underrun(ur)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pos = index of the dibit on the wire, -1 when idle.
  int          pos;
  bit          hv;
  logic [31:0] bufv;
  logic [31:0] cur;
  bit          acc;
  logic [1:0]  e_d;
  bit          e_fs;
  bit          e_busy;
  bit          e_ur;

  logic [31:0] rx_word;
  logic [31:0] last_rx;
  int          rx_cnt;
  int          frames_seen;
  logic [31:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pos = -1;
    hv  = 1'b0;
    sb.delete();
  endtask

  task automatic model_edge();
    bit ending;
    bit start;
    ending = (pos < 0) || (pos == 15);
    start  = ending && hv && tx_en;
    e_ur   = (pos == 15) && !start && tx_en;
    acc    = valid && !hv;
    if (start) begin
      cur = bufv;
      pos = 0;
      hv  = 1'b0;
    end else if (pos == 15) begin
      pos = -1;
    end else if (pos >= 0) begin
      pos++;
    end
    if (acc) begin
      bufv = {2'b10, si, 2'b01, sq};
      hv   = 1'b1;
      sb.push_back(bufv);
    end
    e_fs   = start;
    e_busy = (pos >= 0);
    e_d    = (pos < 0) ? 2'b00 : 2'(cur >> (30 - 2 * pos));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("ddr", {30'd0, ddr}, {30'd0, e_d});
    chk("frame_start", {31'd0, fs}, {31'd0, e_fs});
    chk("busy", {31'd0, busy}, {31'd0, e_busy});
    chk("underrun", {31'd0, ur}, {31'd0, e_ur});
    chk("ready", {31'd0, ready}, {31'd0, !hv});
    if (fs) rx_cnt = 0;
    if (busy) begin
      rx_word = {rx_word[29:0], ddr};
      rx_cnt++;
      if (rx_cnt == 16) begin
        last_rx = rx_word;
        frames_seen++;
        if (sb.size() == 0) chk("sb_extra_frame", rx_word, 32'hDEAD_BEEF);
        else chk("sb_order", rx_word, sb.pop_front());
      end
    end
  endtask

  logic [13:0] t2_i[4] = '{14'h0001, 14'h2AAA, 14'h1555, 14'h3C3C};
  logic [13:0] t2_q[4] = '{14'h3FFE, 14'h0F0F, 14'h2222, 14'h1248};

  initial begin
    int n, fs_cnt, ur_cnt, busy_cnt, cyc;
    bit found;
    rst = 1'b1; tx_en = 1'b0; valid = 1'b0; si = '0; sq = '0;
    rx_word = '0; last_rx = '0; rx_cnt = 0; frames_seen = 0;
    model_reset();
    #1;
    chk("rst_ddr", {30'd0, ddr}, 32'd0);
    chk("rst_fs", {31'd0, fs}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ur", {31'd0, ur}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rel_ready", {31'd0, ready}, 32'd1);

    // Single frame
    tx_en = 1'b1; si = 14'h1234; sq = 14'h0ABC; valid = 1'b1;
    step();
    chk("t1_accept", {31'd0, acc}, 32'd1);
    valid = 1'b0;
    repeat (16) step();
    chk("t1_word", last_rx, 32'h92344ABC);
    step();
    chk("t1_underrun", {31'd0, ur}, 32'd1);
    repeat (3) step();

    // Back-to-back, four samples
    n = 0; fs_cnt = 0; ur_cnt = 0; busy_cnt = 0;
    si = t2_i[0]; sq = t2_q[0]; valid = 1'b1;
    for (int c = 0; c < 90; c++) begin
      step();
      fs_cnt += int'(fs); ur_cnt += int'(ur); busy_cnt += int'(busy);
      if (acc) begin
        n++;
        if (n < 4) begin si = t2_i[n]; sq = t2_q[n]; end
        else valid = 1'b0;
      end
    end
    chk("t2_accepts", n, 4);
    chk("t2_frame_starts", fs_cnt, 4);
    chk("t2_underruns", ur_cnt, 1);
    chk("t2_busy_cycles", busy_cnt, 64);

    // Loopback through bench deframer
    si = 14'h3FFF; sq = 14'h0000; valid = 1'b1;
    n = frames_seen;
    for (int c = 0; c < 22; c++) begin
      step();
      if (acc) valid = 1'b0;
    end
    chk("t3_word", last_rx, 32'hBFFF4000);
    chk("t3_frames", frames_seen - n, 1);

    // Enable gating with a sample buffered
    si = 14'h0AAA; sq = 14'h1555; valid = 1'b1; n = 0; found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      step();
      if (acc) begin
        n++;
        if (n == 1) begin si = 14'h2468; sq = 14'h1357; end
        else valid = 1'b0;
      end
      if (n == 2 && pos == 5) found = 1'b1;
    end
    chk("t4_reach_idx5", {31'd0, found}, 32'd1);
    tx_en = 1'b0;
    ur_cnt = 0;
    repeat (20) begin
      step();
      ur_cnt += int'(ur);
    end
    chk("t4_no_underrun", ur_cnt, 0);
    chk("t4_ready_held", {31'd0, ready}, 32'd0);
    chk("t4_idle", {30'd0, ddr}, 32'd0);
    tx_en = 1'b1;
    step();
    chk("t4_restart", {31'd0, fs}, 32'd1);
    repeat (17) step();

    // Async reset mid-frame
    si = 14'h1111; sq = 14'h2222; valid = 1'b1; found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      step();
      if (acc) valid = 1'b0;
      if (pos == 8) found = 1'b1;
    end
    chk("t5_reach_idx8", {31'd0, found}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_ddr", {30'd0, ddr}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_ready", {31'd0, ready}, 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    #1 chk("t5_ready_rel", {31'd0, ready}, 32'd1);
    fs_cnt = 0;
    repeat (20) begin
      step();
      fs_cnt += int'(fs);
    end
    chk("t5_no_residual", fs_cnt, 0);

    // Randomized traffic with backpressure and enable toggling
    valid = 1'b0;
    cyc = 0;
    repeat (600) begin
      if (!valid && $urandom_range(0, 3) != 0) begin
        si = 14'($urandom); sq = 14'($urandom); valid = 1'b1;
      end
      if ($urandom_range(0, 19) == 0) tx_en = !tx_en;
      step();
      if (acc) valid = 1'b0;
      cyc++;
    end
    valid = 1'b0; tx_en = 1'b1;
    repeat (40) step();
    chk("sb_drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
